// File: rtl/mips_mem_pkg.sv
// Shared definitions for the multicycle MIPS memory responder: state encoding
// and the default placement of the two memory-mapped I/O bytes.
package mips_mem_pkg;

    typedef enum logic {
        ST_LOAD = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    localparam int unsigned DEF_WIDTH = 8;

    // Output port sits at the top byte, input port just below it.
    function automatic int unsigned io_out_adr_default(input int unsigned width);
        return (32'd1 << width) - 32'd1;
    endfunction

    function automatic int unsigned io_in_adr_default(input int unsigned width);
        return (32'd1 << width) - 32'd2;
    endfunction

endpackage

// File: rtl/mips_ram.sv
// Single-port synchronous byte RAM; a read and a write on the same edge return
// the old contents (read-before-write).
module mips_ram #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic             re_i,
    input  logic [WIDTH-1:0] addr_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o
);

    localparam int unsigned DEPTH = 1 << WIDTH;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    // Read port only advances on an accepted read so the output holds otherwise.
    always_ff @(posedge clk) begin
        if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/mips_mem_resp.sv
// Memory-side responder for the 8-bit multicycle MIPS bus: boot-loads RAM from a
// byte stream while holding the processor in reset, then serves its bus and two I/O bytes.
module mips_mem_resp
    import mips_mem_pkg::*;
#(
    parameter int unsigned WIDTH      = DEF_WIDTH,
    parameter bit          LOAD_EN    = 1'b1,
    parameter int unsigned IO_OUT_ADR = io_out_adr_default(WIDTH),
    parameter int unsigned IO_IN_ADR  = io_in_adr_default(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             memread,
    input  logic             memwrite,
    input  logic [WIDTH-1:0] adr,
    input  logic [WIDTH-1:0] writedata,
    output logic [WIDTH-1:0] memdata,
    output logic             cpu_reset,
    input  logic             ld_valid,
    input  logic [7:0]       ld_data,
    input  logic             ld_last,
    output logic             ld_ready,
    input  logic [WIDTH-1:0] io_in,
    output logic [WIDTH-1:0] io_out
);

    localparam logic [WIDTH-1:0] OUT_ADR = WIDTH'(IO_OUT_ADR);
    localparam logic [WIDTH-1:0] IN_ADR  = WIDTH'(IO_IN_ADR);
    localparam logic [WIDTH-1:0] CNT_MAX = '1;

    state_e           state_q;
    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] io_out_q;
    logic [WIDTH-1:0] io_rd_q;
    logic             sel_io_q;
    logic             cpu_reset_q;
    logic             ld_ready_q;

    logic             run;
    logic             ld_hs;
    logic             load_done;
    logic             hit_out;
    logic             hit_in;
    logic             hit_io;
    logic             ram_we;
    logic             ram_re;
    logic [WIDTH-1:0] ram_addr;
    logic [WIDTH-1:0] ram_wdata;
    logic [WIDTH-1:0] ram_rdata;

    assign run       = (state_q == ST_RUN);
    assign ld_hs     = !reset && !run && ld_ready_q && ld_valid;
    // The counter saturates at the top address, which also ends the load.
    assign load_done = ld_hs && (ld_last || (cnt_q == CNT_MAX));

    assign hit_out = (adr == OUT_ADR);
    assign hit_in  = (adr == IN_ADR);
    assign hit_io  = hit_out || hit_in;

    // RAM port is owned by the loader in LOAD and by the processor in RUN.
    assign ram_we    = ld_hs || (!reset && run && memwrite && !hit_io);
    assign ram_re    = !reset && run && memread && !hit_io;
    assign ram_addr  = run ? adr : cnt_q;
    assign ram_wdata = run ? writedata : WIDTH'(ld_data);

    mips_ram #(
        .WIDTH (WIDTH)
    ) u_ram (
        .clk     (clk),
        .we_i    (ram_we),
        .re_i    (ram_re),
        .addr_i  (ram_addr),
        .wdata_i (ram_wdata),
        .rdata_o (ram_rdata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= LOAD_EN ? ST_LOAD : ST_RUN;
            cnt_q       <= '0;
            io_out_q    <= '0;
            io_rd_q     <= '0;
            sel_io_q    <= 1'b1;
            cpu_reset_q <= 1'b1;
            ld_ready_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_LOAD: begin
                    ld_ready_q <= 1'b1;
                    if (ld_hs && (cnt_q != CNT_MAX)) begin
                        cnt_q <= cnt_q + WIDTH'(1);
                    end
                    if (load_done) begin
                        state_q     <= ST_RUN;
                        ld_ready_q  <= 1'b0;
                        cpu_reset_q <= 1'b0;
                    end
                end
                ST_RUN: begin
                    cpu_reset_q <= 1'b0;
                    ld_ready_q  <= 1'b0;
                    // I/O reads capture the pre-write value, matching RAM read-before-write.
                    if (memread) begin
                        if (hit_out) begin
                            sel_io_q <= 1'b1;
                            io_rd_q  <= io_out_q;
                        end else if (hit_in) begin
                            sel_io_q <= 1'b1;
                            io_rd_q  <= io_in;
                        end else begin
                            sel_io_q <= 1'b0;
                        end
                    end
                    if (memwrite && hit_out) begin
                        io_out_q <= writedata;
                    end
                end
                default: begin
                    state_q <= ST_RUN;
                end
            endcase
        end
    end

    assign memdata   = sel_io_q ? io_rd_q : ram_rdata;
    assign cpu_reset = cpu_reset_q;
    assign ld_ready  = ld_ready_q;
    assign io_out    = io_out_q;

endmodule

// File: tb/tb_mips_mem_resp.sv
// Randomised and directed bench for mips_mem_resp against a byte-array reference model.
module tb_mips_mem_resp;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, memread, memwrite, ld_valid, ld_last;
    logic [7:0] adr, writedata, ld_data, io_in;
    logic [7:0] memdata, io_out;
    logic       cpu_reset, ld_ready;

    logic       reset_b, memread_b, memwrite_b;
    logic [7:0] adr_b, wd_b, md_b, io_out_b;
    logic       cpu_reset_b, ld_ready_b;

    mips_mem_resp #(.WIDTH(8), .LOAD_EN(1'b1)) dut (
        .clk(clk), .reset(reset), .memread(memread), .memwrite(memwrite),
        .adr(adr), .writedata(writedata), .memdata(memdata), .cpu_reset(cpu_reset),
        .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last), .ld_ready(ld_ready),
        .io_in(io_in), .io_out(io_out)
    );

    mips_mem_resp #(.WIDTH(8), .LOAD_EN(1'b0)) dut_nl (
        .clk(clk), .reset(reset_b), .memread(memread_b), .memwrite(memwrite_b),
        .adr(adr_b), .writedata(wd_b), .memdata(md_b), .cpu_reset(cpu_reset_b),
        .ld_valid(1'b1), .ld_data(8'hA5), .ld_last(1'b0), .ld_ready(ld_ready_b),
        .io_in(8'h00), .io_out(io_out_b)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    endtask

    // Reference model: what the responder must present after each edge.
    typedef enum {M_WAIT, M_LOAD, M_RUN} mphase_e;
    mphase_e    m_ph = M_WAIT;
    int         m_ptr = 0;
    logic [7:0] m_mem [256];
    bit         m_known [256];
    logic [7:0] e_md = 8'h00, e_io = 8'h00;
    bit         e_mdk = 1'b1, e_cpu = 1'b1, e_rdy = 1'b0;
    bit         chk_en = 1'b0;

    initial for (int i = 0; i < 256; i++) m_known[i] = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            m_ph = M_WAIT; m_ptr = 0; e_io = 8'h00; e_md = 8'h00; e_mdk = 1'b1;
            e_cpu = 1'b1; e_rdy = 1'b0;
        end else begin
            case (m_ph)
                M_WAIT: begin
                    m_ph = M_LOAD; e_rdy = 1'b1;
                end
                M_LOAD: if (ld_valid) begin
                    m_mem[m_ptr] = ld_data; m_known[m_ptr] = 1'b1;
                    if (ld_last || m_ptr == 255) begin
                        m_ph = M_RUN; e_rdy = 1'b0; e_cpu = 1'b0;
                    end else begin
                        m_ptr++;
                    end
                end
                default: begin
                    if (memread) begin
                        if (adr == 8'hFF) begin
                            e_md = e_io; e_mdk = 1'b1;
                        end else if (adr == 8'hFE) begin
                            e_md = io_in; e_mdk = 1'b1;
                        end else begin
                            e_md = m_mem[adr]; e_mdk = m_known[adr];
                        end
                    end
                    if (memwrite) begin
                        if (adr == 8'hFF) e_io = writedata;
                        else if (adr != 8'hFE) begin
                            m_mem[adr] = writedata; m_known[adr] = 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            if (e_mdk) chk("model_memdata", memdata, e_md);
            chk("model_io_out", io_out, e_io);
            chk("model_cpu_reset", cpu_reset, e_cpu);
            chk("model_ld_ready", ld_ready, e_rdy);
        end
    end

    task automatic idle();
        memread = 1'b0; memwrite = 1'b0; ld_valid = 1'b0; ld_last = 1'b0;
    endtask

    task automatic cyc(); @(negedge clk); endtask

    task automatic bus_rd(input logic [7:0] a);
        idle(); memread = 1'b1; adr = a; cyc(); memread = 1'b0;
    endtask

    task automatic bus_wr(input logic [7:0] a, input logic [7:0] d);
        idle(); memwrite = 1'b1; adr = a; writedata = d; cyc(); memwrite = 1'b0;
    endtask

    task automatic load_byte(input logic [7:0] d, input logic last);
        ld_valid = 1'b1; ld_data = d; ld_last = last; cyc(); ld_valid = 1'b0; ld_last = 1'b0;
    endtask

    logic [7:0] full [256];
    logic [7:0] boot4 [4];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        boot4[0] = 8'h20; boot4[1] = 8'h01; boot4[2] = 8'h00; boot4[3] = 8'h05;
        for (int i = 0; i < 256; i++) full[i] = 8'($urandom);
        reset = 1'b1; reset_b = 1'b1; adr = 8'h00; writedata = 8'h00; ld_data = 8'h00; io_in = 8'h00;
        memread_b = 1'b0; memwrite_b = 1'b0; adr_b = 8'h00; wd_b = 8'h00;
        idle();
        cyc(); cyc();
        chk_en = 1'b1;
        chk("rst_memdata", memdata, 8'h00);
        chk("rst_io_out", io_out, 8'h00);
        chk("rst_cpu_reset", cpu_reset, 1'b1);
        chk("rst_ld_ready", ld_ready, 1'b0);
        chk("nl_rst_cpu_reset", cpu_reset_b, 1'b1);
        chk("nl_rst_ld_ready", ld_ready_b, 1'b0);

        // Release both; the LOAD_EN=0 instance must run after one edge.
        reset = 1'b0; reset_b = 1'b0;
        chk("nl_cpu_reset_before_edge", cpu_reset_b, 1'b1);
        cyc();
        chk("nl_cpu_reset_fell", cpu_reset_b, 1'b0);
        chk("nl_ld_ready_low", ld_ready_b, 1'b0);
        chk("ld_ready_up", ld_ready, 1'b1);
        memwrite_b = 1'b1; adr_b = 8'h05; wd_b = 8'h11; cyc();
        memwrite_b = 1'b0; memread_b = 1'b1; cyc(); memread_b = 1'b0;
        chk("nl_rw", md_b, 8'h11);
        chk("nl_ld_ready_stays", ld_ready_b, 1'b0);

        // Full load without ld_last.
        for (int i = 0; i < 256; i++) begin
            if (i == 255) begin
                chk("full_cpu_reset_pre", cpu_reset, 1'b1);
                chk("full_ld_ready_pre", ld_ready, 1'b1);
            end
            ld_valid = 1'b1; ld_data = full[i]; ld_last = 1'b0; cyc();
        end
        chk("full_cpu_reset_post", cpu_reset, 1'b0);
        chk("full_ld_ready_post", ld_ready, 1'b0);
        ld_data = 8'hEE; cyc(); cyc(); cyc();
        idle();
        bus_rd(8'h00);
        chk("full_rd0", memdata, {24'h0, full[0]});
        bus_rd(8'h80);
        chk("full_rd80", memdata, {24'h0, full[128]});

        // Reset and the 4-byte boot program.
        reset = 1'b1; cyc(); reset = 1'b0;
        chk("rl_cpu_reset", cpu_reset, 1'b1);
        cyc();
        for (int i = 0; i < 4; i++) begin
            if (i == 3) chk("b4_cpu_reset_pre", cpu_reset, 1'b1);
            load_byte(boot4[i], i == 3);
        end
        chk("b4_cpu_reset_post", cpu_reset, 1'b0);
        chk("b4_ld_ready_post", ld_ready, 1'b0);
        for (int i = 0; i < 4; i++) begin
            bus_rd(8'(i));
            chk($sformatf("b4_rd%0d", i), memdata, {24'h0, boot4[i]});
        end
        bus_rd(8'h04);
        chk("b4_rd4_kept", memdata, {24'h0, full[4]});

        // RUN write then read, then same-cycle read+write.
        bus_wr(8'h10, 8'h5A);
        bus_rd(8'h10);
        chk("wr_rd_10", memdata, 8'h5A);
        memread = 1'b1; memwrite = 1'b1; adr = 8'h10; writedata = 8'h77; cyc(); idle();
        chk("rbw_old", memdata, 8'h5A);
        bus_rd(8'h10);
        chk("rbw_new", memdata, 8'h77);

        // I/O decode.
        bus_wr(8'hFF, 8'hC3);
        chk("io_out_c3", io_out, 8'hC3);
        chk("ram_ff_untouched", dut.u_ram.mem_q[255], {24'h0, full[255]});
        bus_rd(8'hFF);
        chk("rd_io_out", memdata, 8'hC3);
        io_in = 8'h3C;
        bus_rd(8'hFE);
        chk("rd_io_in", memdata, 8'h3C);
        bus_wr(8'hFE, 8'h99);
        chk("io_in_wr_dropped_io", io_out, 8'hC3);

        // Random bus traffic, checked every cycle by the model.
        for (int n = 0; n < 400; n++) begin
            int r;
            r = int'($urandom_range(0, 19));
            memread = 1'($urandom);
            memwrite = ($urandom_range(0, 2) == 0);
            adr = (r < 16) ? 8'(8'h20 + r) : ((r < 18) ? 8'hFE : 8'hFF);
            writedata = 8'($urandom);
            io_in = 8'($urandom);
            cyc();
        end
        idle();

        // Reset mid-run, then a one-byte reload.
        bus_wr(8'hFF, 8'hC3);
        reset = 1'b1; cyc(); reset = 1'b0;
        chk("mr_io_out", io_out, 8'h00);
        chk("mr_memdata", memdata, 8'h00);
        chk("mr_cpu_reset", cpu_reset, 1'b1);
        cyc();
        chk("mr_ld_ready", ld_ready, 1'b1);
        load_byte(8'hAB, 1'b1);
        chk("rl1_cpu_reset", cpu_reset, 1'b0);
        bus_rd(8'h00);
        chk("rl1_rd0", memdata, 8'hAB);
        bus_rd(8'h01);
        chk("rl1_rd1", memdata, 8'h01);
        bus_rd(8'h10);
        chk("rl1_rd10", memdata, 8'h77);

        // Reset in the middle of a load.
        reset = 1'b1; cyc(); reset = 1'b0; cyc();
        load_byte(8'h11, 1'b0);
        load_byte(8'h22, 1'b0);
        memread = 1'b1; adr = 8'h00; cyc(); memread = 1'b0;
        chk("ld_bus_ignored", memdata, 8'h00);
        reset = 1'b1; cyc(); reset = 1'b0; cyc();
        ld_valid = 1'b0; cyc();
        load_byte(8'h99, 1'b1);
        for (int i = 0; i < 4; i++) bus_rd(8'(i));
        bus_rd(8'h01);
        chk("ml_rd1", memdata, 8'h22);
        bus_rd(8'h00);
        chk("ml_rd0", memdata, 8'h99);
        cyc();

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
